// File: rtl/final_adder_pipe_pkg.sv
// Shared definitions for the final carry-propagate adder and the multiplier top.
// Optional signed-overflow output is enabled with the FINAL_ADDER_OVF_EN macro.
package final_adder_pipe_pkg;

  localparam int unsigned SLICE_W = 4;
  localparam int unsigned PROD_W  = 32;

  // Pipeline depth for a given width and number of slices chained per stage
  function automatic int unsigned calc_stages(input int unsigned width,
                                              input int unsigned slices_per_stage);
    return width / (SLICE_W * slices_per_stage);
  endfunction

  // Product bundle handed to the multiplier top
  typedef struct packed {
    logic [PROD_W-1:0] result;
    logic              cout;
    logic              ovf;
  } final_add_res_t;

endpackage

// File: rtl/final_adder_pipe_ling_adder_4bit.sv
// 4-bit Ling adder slice: pseudo-carries h_i, real carries c_i = t_(i-1) & h_i.
module ling_adder_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_g;
  logic [3:0] w_t;
  logic [3:0] w_d;
  logic [4:1] w_h;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_t = i_a | i_b;
  assign w_d = i_a ^ i_b;

  // Flattened Ling pseudo-carry terms
  assign w_h[1] = w_g[0] | i_cin;
  assign w_h[2] = w_g[1] | w_g[0] | (w_t[0] & i_cin);
  assign w_h[3] = w_g[2] | w_g[1] | (w_t[1] & w_g[0]) | (w_t[1] & w_t[0] & i_cin);
  assign w_h[4] = w_g[3] | w_g[2] | (w_t[2] & w_g[1]) | (w_t[2] & w_t[1] & w_g[0])
                | (w_t[2] & w_t[1] & w_t[0] & i_cin);

  assign w_c[0] = i_cin;
  assign w_c[1] = w_t[0] & w_h[1];
  assign w_c[2] = w_t[1] & w_h[2];
  assign w_c[3] = w_t[2] & w_h[3];
  assign w_c[4] = w_t[3] & w_h[4];

  assign o_sum  = w_d ^ w_c[3:0];
  assign o_cout = w_c[4];

endmodule

// File: rtl/final_adder_pipe.sv
// Pipelined final adder: sum + carry + cin over STAGES stages of Ling slices.
// Operand bits skew forward, finished result bits ride along so all bits align.
// Define FINAL_ADDER_OVF_EN to add the registered out_ovf signed-overflow output.
module final_adder_pipe
  import final_adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned SLICES_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout
`ifdef FINAL_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned CW     = SLICE_W * SLICES_PER_STAGE;
  localparam int unsigned STAGES = calc_stages(WIDTH, SLICES_PER_STAGE);
  localparam int unsigned LAST   = STAGES - 1;

  logic w_adv;

  // Whole pipe advances together; a stalled output freezes every stage
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv && rst_n;

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    localparam int unsigned BW = WIDTH - CW * k;

    logic [WIDTH-1:0]          w_src_a;
    logic [BW-1:0]             w_src_b;
    logic                      w_src_c;
    logic                      w_src_v;
    logic [WIDTH-1:0]          w_nxt_a;
    logic [CW-1:0]             w_sum;
    logic [SLICES_PER_STAGE:0] w_cy;
    logic [WIDTH-1:0]          r_a;
    logic                      r_c;
    logic                      r_v;

    if (k == 0) begin : gen_src_in
      assign w_src_a = in_sum;
      assign w_src_b = in_carry;
      assign w_src_c = in_cin;
      assign w_src_v = in_valid;
    end else begin : gen_src_reg
      assign w_src_a = gen_stage[k-1].r_a;
      assign w_src_b = gen_stage[k-1].gen_b.r_b;
      assign w_src_c = gen_stage[k-1].r_c;
      assign w_src_v = gen_stage[k-1].r_v;
    end

    assign w_cy[0] = w_src_c;

    for (genvar j = 0; j < SLICES_PER_STAGE; j++) begin : gen_slice
      ling_adder_4bit u_slice (
        .i_a    (w_src_a[CW*k + SLICE_W*j +: SLICE_W]),
        .i_b    (w_src_b[SLICE_W*j +: SLICE_W]),
        .i_cin  (w_cy[j]),
        .o_sum  (w_sum[SLICE_W*j +: SLICE_W]),
        .o_cout (w_cy[j+1])
      );
    end

    // Splice this stage's finished bits into the operand/result word
    always_comb begin
      w_nxt_a               = w_src_a;
      w_nxt_a[CW*k +: CW]   = w_sum;
    end

    // Stage register: result/operand word, stage carry-out and valid
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_a <= '0;
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (w_adv) begin
        r_a <= w_nxt_a;
        r_c <= w_cy[SLICES_PER_STAGE];
        r_v <= w_src_v;
      end
    end

    if (k < LAST) begin : gen_b
      logic [BW-CW-1:0] r_b;

      // Remaining carry-vector bits for the later stages
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_b <= '0;
        end else if (w_adv) begin
          r_b <= w_src_b[BW-1:CW];
        end
      end
    end
  end

  assign out_valid  = gen_stage[LAST].r_v;
  assign out_result = gen_stage[LAST].r_a;
  assign out_cout   = gen_stage[LAST].r_c;

`ifdef FINAL_ADDER_OVF_EN
  logic r_ovf;

  // Signed overflow from the operand MSBs arriving at the last stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= (gen_stage[LAST].w_src_a[WIDTH-1] == gen_stage[LAST].w_src_b[CW-1])
            && (gen_stage[LAST].w_nxt_a[WIDTH-1] != gen_stage[LAST].w_src_a[WIDTH-1]);
    end
  end

  assign out_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_final_adder_pipe.sv
// Self-checking bench for final_adder_pipe (WIDTH=16, one slice per stage, 4 stages).
// Build with FINAL_ADDER_OVF_EN defined to also check out_ovf.
module tb_final_adder_pipe;

  localparam int unsigned W   = 16;
  localparam int          LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_carry;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_cout;
`ifdef FINAL_ADDER_OVF_EN
  logic         out_ovf;
`endif

  final_adder_pipe #(
    .WIDTH            (W),
    .SLICES_PER_STAGE (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_cin     (in_cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout)
`ifdef FINAL_ADDER_OVF_EN
    ,
    .out_ovf    (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    int           t;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  bit           lat_en = 1'b0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] prev_res;
  logic         prev_cout;

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sums, signed overflow from the signed range
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    int   u;
    int   s;
    u      = int'(a) + int'(b) + int'(c);
    s      = int'($signed(a)) + int'($signed(b)) + int'(c);
    e.res  = W'(u % 65536);
    e.cout = (u >= 65536);
    e.ovf  = (s > 32767) || (s < -32768);
    e.t    = cyc;
    return e;
  endfunction

  // One clock: score transfers that happen at the coming edge, then advance
  task automatic cycle();
    exp_t e;
    bit   in_x;
    bit   out_x;
    #1;
    in_x  = in_valid && in_ready;
    out_x = out_valid && out_ready;
    if (stall_prev) begin
      chk("hold_result", {1'b0, out_result}, {1'b0, prev_res});
      chk("hold_cout", {{W{1'b0}}, out_cout}, {{W{1'b0}}, prev_cout});
      chk("hold_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
    end
    stall_prev = out_valid && !out_ready;
    prev_res   = out_result;
    prev_cout  = out_cout;
    if (out_x) begin
      if (q.size() == 0) begin
        chk("spurious_out", {{W{1'b0}}, 1'b1}, {{W{1'b0}}, 1'b0});
      end else begin
        e = q.pop_front();
        chk("result", {out_cout, out_result}, {e.cout, e.res});
`ifdef FINAL_ADDER_OVF_EN
        chk("ovf", {{W{1'b0}}, out_ovf}, {{W{1'b0}}, e.ovf});
`endif
        if (lat_en) chk("latency", (W+1)'(cyc - e.t), (W+1)'(LAT));
      end
    end
    if (in_x) q.push_back(model(in_sum, in_carry, in_cin));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    // Reset state
    chk("rst_valid", {{W{1'b0}}, out_valid}, '0);
    chk("rst_result", {1'b0, out_result}, '0);
    chk("rst_cout", {{W{1'b0}}, out_cout}, '0);
    chk("rst_in_ready", {{W{1'b0}}, in_ready}, '0);
`ifdef FINAL_ADDER_OVF_EN
    chk("rst_ovf", {{W{1'b0}}, out_ovf}, '0);
`endif
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});

    // Worst-case ripple: FFFF + 0001 with exact latency
    lat_en    = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 16'hFFFF;
    in_carry  = 16'h0001;
    in_cin    = 1'b0;
    cycle();
    in_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      chk("ripple_early_valid", {{W{1'b0}}, out_valid}, '0);
      cycle();
    end
    chk("ripple_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
    chk("ripple_sum", {out_cout, out_result}, {1'b1, 16'h0000});
    cycle();

    // Back-to-back random pairs
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sum   = W'($urandom);
      in_carry = W'($urandom);
      in_cin   = 1'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    repeat (LAT + 1) cycle();
    chk("b2b_drained", (W+1)'(q.size()), '0);

    // Backpressure with a full pipe
    lat_en = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      in_valid = 1'b1;
      in_sum   = W'($urandom);
      in_carry = W'($urandom);
      in_cin   = 1'($urandom);
      cycle();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_sum   = W'($urandom);
      in_carry = W'($urandom);
      #1;
      chk("bp_in_ready", {{W{1'b0}}, in_ready}, '0);
      cycle();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (LAT + 2) cycle();
    chk("bp_drained", (W+1)'(q.size()), '0);

    // Bubble pattern 1,0,1
    lat_en   = 1'b1;
    in_valid = 1'b1;
    in_sum   = 16'h1234;
    in_carry = 16'h4321;
    in_cin   = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    in_valid = 1'b1;
    in_sum   = 16'h8000;
    in_carry = 16'h8000;
    in_cin   = 1'b0;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("bubble_v0", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
    cycle();
    chk("bubble_v1", {{W{1'b0}}, out_valid}, '0);
    cycle();
    chk("bubble_v2", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
    cycle();

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sum   = W'($urandom);
      in_carry = W'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_in_ready", {{W{1'b0}}, in_ready}, '0);
    cycle();
    q.delete();
    rst_n = 1'b1;
    chk("midrst_valid", {{W{1'b0}}, out_valid}, '0);
    chk("midrst_result", {out_cout, out_result}, '0);
    for (int i = 0; i < LAT + 2; i++) begin
      chk("midrst_no_stale", {{W{1'b0}}, out_valid}, '0);
      cycle();
    end

    // Overflow corner operands
    in_valid = 1'b1;
    in_sum   = 16'h7FFF;
    in_carry = 16'h0001;
    in_cin   = 1'b0;
    cycle();
    in_sum   = 16'hFFFF;
    in_carry = 16'h0001;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    chk("ovf_case1_sum", {out_cout, out_result}, {1'b0, 16'h8000});
`ifdef FINAL_ADDER_OVF_EN
    chk("ovf_case1_flag", {{W{1'b0}}, out_ovf}, {{W{1'b0}}, 1'b1});
`endif
    cycle();
    chk("ovf_case2_sum", {out_cout, out_result}, {1'b1, 16'h0000});
`ifdef FINAL_ADDER_OVF_EN
    chk("ovf_case2_flag", {{W{1'b0}}, out_ovf}, '0);
`endif
    cycle();

    // Random traffic with random backpressure
    lat_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom);
      in_sum    = W'($urandom);
      in_carry  = W'($urandom);
      in_cin    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (LAT + 2) cycle();
    chk("final_drained", (W+1)'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
